// File: rtl/gray_updown_counter_pkg.sv
// Shared Gray-code helpers and counter mode constants.
// Pointer-synchroniser blocks reuse the conversion functions from here.
package gray_pkg;

   localparam int GRAY_WRAP = 0;
   localparam int GRAY_SAT  = 1;

   typedef enum logic [1:0] {
      OP_HOLD,
      OP_LOAD,
      OP_UP,
      OP_DOWN
   } gray_op_e;

   function automatic logic [31:0] bin2gray(input logic [31:0] b);
      return b ^ (b >> 1);
   endfunction

   // Prefix XOR by doubling shifts; the upper bits are zero for narrower
   // values, so the result is correct for any width up to 32.
   function automatic logic [31:0] gray2bin(input logic [31:0] g);
      logic [31:0] b;
      b = g;
      for (int s = 1; s < 32; s = s * 2) begin
         b = b ^ (b >> s);
      end
      return b;
   endfunction

endpackage

// File: rtl/gray_updown_counter_if.sv
// Control and count bus of the Gray up/down counter.
interface gray_updown_counter_if #(
   parameter int N = 4
);
   logic         clk_en;
   logic         up;
   logic         load;
   logic [N-1:0] load_val;
   logic [N-1:0] gray_out;
   logic [N-1:0] bin_out;
   logic         tc;
   logic         wrap;

   modport master (
      output clk_en, up, load, load_val,
      input  gray_out, bin_out, tc, wrap
   );

   modport slave (
      input  clk_en, up, load, load_val,
      output gray_out, bin_out, tc, wrap
   );
endinterface

// File: rtl/gray_updown_counter_gray2bin.sv
// Combinational Gray-to-binary decoder: each binary bit is the XOR of all
// Gray bits at or above its position.
module gray2bin #(
   parameter int N = 4
) (
   input  logic [N-1:0] gray_i,
   output logic [N-1:0] bin_o
);
   for (genvar gi = 0; gi < N; gi++) begin : g_bit
      assign bin_o[gi] = ^gray_i[N-1:gi];
   end
endmodule

// File: rtl/gray_updown_counter.sv
// N-bit Gray up/down counter with synchronous load, wrap/saturate policy,
// registered Gray and binary views, a wrap pulse and a terminal-count flag.
module gray_updown_counter
   import gray_pkg::*;
#(
   parameter int N        = 4,
   parameter int SATURATE = GRAY_WRAP
) (
   input  logic                  clk,
   input  logic                  rst,
   gray_updown_counter_if.slave  bus
);
   localparam logic [N-1:0] MAX_VAL = {N{1'b1}};
   localparam logic [N-1:0] ONE     = {{(N-1){1'b0}}, 1'b1};
   localparam bit           SAT_EN  = (SATURATE == GRAY_SAT);

   logic [N-1:0] bin_q, bin_d;
   logic [N-1:0] gray_q, gray_d;
   logic         wrap_q, wrap_d;
   logic [N-1:0] load_bin;
   gray_op_e     op;

   gray2bin #(.N(N)) u_load_dec (
      .gray_i (bus.load_val),
      .bin_o  (load_bin)
   );

   always_comb begin
      op = OP_HOLD;
      if (bus.load)
         op = OP_LOAD;
      else if (bus.clk_en)
         op = bus.up ? OP_UP : OP_DOWN;
   end

   always_comb begin
      bin_d  = bin_q;
      wrap_d = 1'b0;
      case (op)
         OP_LOAD: bin_d = load_bin;
         OP_UP: begin
            if (bin_q == MAX_VAL) begin
               if (!SAT_EN) begin
                  bin_d  = '0;
                  wrap_d = 1'b1;
               end
            end else begin
               bin_d = bin_q + ONE;
            end
         end
         OP_DOWN: begin
            if (bin_q == '0) begin
               if (!SAT_EN) begin
                  bin_d  = MAX_VAL;
                  wrap_d = 1'b1;
               end
            end else begin
               bin_d = bin_q - ONE;
            end
         end
         default: bin_d = bin_q;
      endcase
   end

   // Gray is encoded from the next binary value so both views update together.
   always_comb begin
      gray_d = N'(bin2gray(32'(bin_d)));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bin_q  <= '0;
         gray_q <= '0;
         wrap_q <= 1'b0;
      end else begin
         bin_q  <= bin_d;
         gray_q <= gray_d;
         wrap_q <= wrap_d;
      end
   end

   assign bus.bin_out  = bin_q;
   assign bus.gray_out = gray_q;
   assign bus.wrap     = wrap_q;
   assign bus.tc       = bus.up ? (bin_q == MAX_VAL) : (bin_q == '0);

endmodule

// File: tb/tb_gray_updown_counter.sv
// Drives a wrap-mode and a saturate-mode counter with shared stimulus and
// checks both against an arithmetic reference model every cycle.
module tb_gray_updown_counter;
   localparam int N    = 4;
   localparam int MAXV = (1 << N) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ce_s = 1'b0, up_s = 1'b1, load_s = 1'b0;
   logic [N-1:0] lv_s = '0;

   int vectors = 0;
   int miscompares = 0;

   int m_bin [2] = '{0, 0};
   bit m_wrap[2] = '{0, 0};
   bit m_step[2] = '{0, 0};
   int prev_g[2] = '{0, 0};

   gray_updown_counter_if #(.N(N)) if_w ();
   gray_updown_counter_if #(.N(N)) if_s ();

   assign if_w.clk_en = ce_s;  assign if_s.clk_en = ce_s;
   assign if_w.up = up_s;      assign if_s.up = up_s;
   assign if_w.load = load_s;  assign if_s.load = load_s;
   assign if_w.load_val = lv_s; assign if_s.load_val = lv_s;

   gray_updown_counter #(.N(N), .SATURATE(0)) dut_w (.clk(clk), .rst(rst), .bus(if_w));
   gray_updown_counter #(.N(N), .SATURATE(1)) dut_s (.clk(clk), .rst(rst), .bus(if_s));

   always #5 clk = ~clk;

   // Decode by searching for the count whose Gray code matches.
   function automatic int decode(input int g);
      for (int b = 0; b <= MAXV; b++) begin
         if ((b ^ (b >> 1)) == g) return b;
      end
      return -1;
   endfunction

   function automatic void model_next(input int k, input int cur, output int nb,
                                      output bit nw, output bit ns);
      int t;
      nw = 0;
      ns = 0;
      nb = cur;
      if (load_s) begin
         nb = decode(int'(lv_s));
      end else if (ce_s) begin
         t = up_s ? cur + 1 : cur - 1;
         if (t > MAXV || t < 0) begin
            if (k == 0) begin
               t  = up_s ? 0 : MAXV;
               nw = 1;
            end else begin
               t = cur;
            end
         end
         ns = (t != cur);
         nb = t;
      end
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < 2; k++) begin
            m_bin[k]  <= 0;
            m_wrap[k] <= 0;
            m_step[k] <= 0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            int nb;
            bit nw, ns;
            model_next(k, m_bin[k], nb, nw, ns);
            m_bin[k]  <= nb;
            m_wrap[k] <= nw;
            m_step[k] <= ns;
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_dut(input int k, input int g, input int b, input int w, input int t);
      int eg, et;
      string tag;
      tag = (k == 0) ? "wrapdut" : "satdut";
      eg = m_bin[k] ^ (m_bin[k] >> 1);
      et = up_s ? int'(m_bin[k] == MAXV) : int'(m_bin[k] == 0);
      chk({tag, ".bin"}, b, m_bin[k]);
      chk({tag, ".gray"}, g, eg);
      chk({tag, ".wrap"}, w, int'(m_wrap[k]));
      chk({tag, ".tc"}, t, et);
      if (m_step[k]) chk({tag, ".onebit"}, $countones(g ^ prev_g[k]), 1);
      prev_g[k] = g;
   endtask

   always @(negedge clk) begin
      check_dut(0, int'(if_w.gray_out), int'(if_w.bin_out), int'(if_w.wrap), int'(if_w.tc));
      check_dut(1, int'(if_s.gray_out), int'(if_s.bin_out), int'(if_s.wrap), int'(if_s.tc));
   end

   task automatic cyc(input logic ce, input logic u, input logic ld, input logic [N-1:0] lv);
      ce_s = ce; up_s = u; load_s = ld; lv_s = lv;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int gseq[4];
      int dseq_s[4];
      int dseq_w[4];
      gseq   = '{1, 3, 2, 6};
      dseq_s = '{1, 0, 0, 0};
      dseq_w = '{1, 0, 15, 14};

      // Reset held with enable high, then release.
      #1 rst = 1'b0;
      ce_s = 1'b1; up_s = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      chk("rst.gray", int'(if_w.gray_out), 0);
      chk("rst.wrap", int'(if_w.wrap), 0);
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc(1, 1, 0, '0);
         chk("rel.bin", int'(if_w.bin_out), i + 1);
         chk("rel.gray", int'(if_w.gray_out), gseq[i]);
      end

      // Load wins over count.
      cyc(1, 1, 1, 4'b0111);
      chk("load.bin", int'(if_w.bin_out), 5);
      chk("load.gray", int'(if_w.gray_out), 7);
      chk("load.wrap", int'(if_w.wrap), 0);
      cyc(1, 1, 0, '0);
      chk("load.next.gray", int'(if_w.gray_out), 5);

      // Up to the top and wrap.
      repeat (9) cyc(1, 1, 0, '0);
      chk("top.bin", int'(if_w.bin_out), 15);
      chk("top.tc", int'(if_w.tc), 1);
      chk("top.gray", int'(if_w.gray_out), 8);
      cyc(1, 1, 0, '0);
      chk("wrap.bin", int'(if_w.bin_out), 0);
      chk("wrap.pulse", int'(if_w.wrap), 1);
      chk("sat.top.hold", int'(if_s.bin_out), 15);
      cyc(1, 1, 0, '0);
      chk("wrap.clear", int'(if_w.wrap), 0);

      // Down count from 2: saturate vs wrap.
      cyc(1, 1, 1, 4'b0011);
      for (int i = 0; i < 4; i++) begin
         cyc(1, 0, 0, '0);
         chk("sat.down.bin", int'(if_s.bin_out), dseq_s[i]);
         chk("sat.down.wrap", int'(if_s.wrap), 0);
         chk("wrapm.down.bin", int'(if_w.bin_out), dseq_w[i]);
      end
      chk("sat.down.tc", int'(if_s.tc), 1);

      // Enable gating and direction reversal from 7.
      cyc(1, 1, 1, 4'b0100);
      repeat (3) begin
         cyc(0, 1, 0, '0);
         chk("gate.hold", int'(if_w.bin_out), 7);
      end
      cyc(1, 1, 0, '0); chk("rev.1", int'(if_w.bin_out), 8);
      cyc(1, 0, 0, '0); chk("rev.2", int'(if_w.bin_out), 7);
      cyc(1, 1, 0, '0); chk("rev.3", int'(if_w.bin_out), 8);
      cyc(1, 0, 0, '0); chk("rev.4", int'(if_w.bin_out), 7);

      // Asynchronous reset between edges at 9.
      cyc(1, 1, 1, 4'b1101);
      chk("pre.async.bin", int'(if_w.bin_out), 9);
      ce_s = 1'b1; up_s = 1'b1; load_s = 1'b0;
      #2 rst = 1'b0;
      #1;
      chk("async.bin", int'(if_w.bin_out), 0);
      chk("async.gray", int'(if_s.gray_out), 0);
      @(posedge clk); #1 rst = 1'b1;
      chk("async.hold", int'(if_w.bin_out), 0);
      cyc(1, 1, 0, '0);
      chk("async.resume", int'(if_w.bin_out), 1);

      // Random traffic with occasional mid-cycle resets.
      for (int i = 0; i < 400; i++) begin
         if (i % 97 == 50) begin
            #2 rst = 1'b0;
            #3 rst = 1'b1;
         end
         cyc($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
             $urandom_range(0, 7) == 0, N'($urandom_range(0, MAXV)));
      end

      @(negedge clk); #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/gray_updown_counter.md
# gray_updown_counter

Parametrised N-bit Gray-code counter with count direction, synchronous load, a selectable wrap/saturate policy and terminal-count/wrap flags. It is the next generation of the team's fixed-direction Gray counter. It supplies Gray-coded pointers and sequence values to clock-domain-crossing and lab datapath blocks. Both a Gray and a binary view of the count are registered outputs.

## Interface

**Parameters**
- `N`, default 4: counter width in bits; legal range ≥ 2.
- `SATURATE`, default 0: 0 = wrap at the extremes; 1 = hold at the extremes.

**Ports**
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- `clk_en`  in  1  count enable; when low, the count holds.
- `up`  in  1  direction: 1 = increment, 0 = decrement; sampled only when counting.
- `load`  in  1  synchronous load strobe.
- `load_val`  in  N  Gray-coded value to load.
- `gray_out`  out  N  registered Gray count.
- `bin_out`  out  N  registered binary equivalent of `gray_out`.
- `tc`  out  1  terminal count, combinational from registered state: 1 when (`up`=1 and `bin_out`=2^N−1) or (`up`=0 and `bin_out`=0).
- `wrap`  out  1  registered one-cycle pulse; high in the cycle after a count wrapped around.

## Operation

- **Internal state:** binary register `bin_q[N-1:0]`. Gray output is `gray_q = next_bin ^ (next_bin >> 1)`, registered on the same edge, so `gray_out` always equals `bin_out ^ (bin_out >> 1)`.
- **Next-state priority, evaluated each rising edge:**
  1. `load`=1: `bin_q` ← gray2bin(`load_val`). `load` ignores `clk_en` and `up`. `wrap` ← 0.
  2. Else if `clk_en`=1 and `up`=1:
     - If `bin_q`=2^N−1 and `SATURATE`=0: `bin_q` ← 0, `wrap` ← 1.
     - If `bin_q`=2^N−1 and `SATURATE`=1: hold, `wrap` ← 0.
     - Otherwise: `bin_q` ← `bin_q`+1 (N-bit arithmetic), `wrap` ← 0.
  3. Else if `clk_en`=1 and `up`=0:
     - If `bin_q`=0 and `SATURATE`=0: `bin_q` ← 2^N−1, `wrap` ← 1.
     - If `bin_q`=0 and `SATURATE`=1: hold, `wrap` ← 0.
     - Otherwise: `bin_q` ← `bin_q`−1, `wrap` ← 0.
  4. Else: hold, `wrap` ← 0.
- **Gray property:** each count step changes exactly one bit of `gray_out`, including the wrap step. A load may change any number of bits.
- **Direction reversal:** `up` may change on any cycle. The step uses the value of `up` at that edge, with no dead cycle.
- **Load vs. count:** simultaneous `load` and `clk_en` resolves to the load.
- **Gray decode:** gray2bin is prefix XOR, `b[N-1]=g[N-1]`, `b[i]=b[i+1]^g[i]`. It is purely combinational.

## Timing

- **Reset:** `rst`=0 asynchronously forces `bin_out`=0, `gray_out`=0 and `wrap`=0. `tc` is then 1 if `up`=0, else 0.
- **Reset mid-count:** outputs clear immediately without waiting for a clock edge. The first count after release occurs on the first rising edge where `rst`=1 and `clk_en`=1.
- **Latency:** one cycle from `clk_en`/`load` sampled high to the new value on `gray_out` and `bin_out`.
- **`wrap`:** valid in the same cycle as the wrapped value. It is asserted for exactly one cycle per wrap and never asserted when `SATURATE`=1.
- **`tc`:** combinational, with no added latency. It reflects the current `up`, so it may toggle on a direction change without any state change.
- **Registered outputs:** `gray_out`, `bin_out` and `wrap` come directly from flops, with no combinational path from inputs.

## Structure

- **Shared package `gray_pkg`:** holds the `SATURATE` mode constants `GRAY_WRAP`=0 and `GRAY_SAT`=1, plus the `gray2bin`/`bin2gray` functions for reuse by pointer-synchroniser blocks.
- **Sub-module `gray2bin`:** parametrised by `N`, combinational, instantiated once on the load path. Keeping it separate lets it be verified standalone and reused.
- **Top level:** a single sequential block for `bin_q`/`gray_q`/`wrap_q`, plus combinational next-state and `tc` logic.

## Test plan

- **Reset and release, N=4:** hold `rst`=0 with `clk_en`=1, then release → `gray_out`=0000 during reset. Afterwards it follows 0001, 0011, 0010, 0110 on successive edges, and `bin_out` follows 1, 2, 3, 4.
- **Full up-cycle, wrap mode:** 16 enabled edges from 0 → `gray_out` returns to 0000 from 1000. `wrap`=1 for exactly one cycle and `tc`=1 while `bin_out`=15. Exactly one bit changes on every step.
- **Down count with `SATURATE`=1:** `up`=0 from `bin_out`=2 for 4 edges → 1, 0, 0, 0. `wrap` is never asserted and `tc`=1 while at 0.
- **Load priority:** `load`=1, `load_val`=0111 and `clk_en`=1 together → next cycle `gray_out`=0111, `bin_out`=5, `wrap`=0. A following up count gives `gray_out`=0101 (bin 6).
- **Enable gating and direction reversal:** with `clk_en`=0 for 3 edges, the count holds. Then alternate `up` 1/0 with `clk_en`=1 from 7 → `bin_out` sequence 8, 7, 8, 7.
- **Asynchronous reset mid-count:** assert `rst` between edges while at `bin_out`=9 → outputs go to 0 before the next edge. After release they resume from 0.
